// File: rtl/serv_mem_arbiter_pkg.sv
// Shared constants for the SERV memory arbiter.
//   - FSM state encodings (3-bit, kept as plain constants for legacy tools)
//   - error codes reported on o_err_code
//   - addr_fits(): true when a 32-bit core address lies inside the memory port
package serv_mem_arbiter_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_IBUS  = 3'd1;
  localparam logic [2:0] S_DBUS  = 3'd2;
  localparam logic [2:0] S_ERR_I = 3'd3;
  localparam logic [2:0] S_ERR_D = 3'd4;

  localparam logic [1:0] ERR_CODE_RANGE   = 2'b01;
  localparam logic [1:0] ERR_CODE_TIMEOUT = 2'b10;

  // All address bits above the port width must be zero.
  function automatic logic addr_fits(logic [31:0] adr, int unsigned aw);
    return (aw >= 32) || ((adr >> aw) == 32'd0);
  endfunction

endpackage

// File: rtl/serv_mem_arbiter_if.sv
// Bus bundle between SERV (ibus + dbus), the arbiter and the shared memory port.
//   slave  : arbiter view (takes core requests and memory responses,
//            drives memory requests and core responses)
//   master : environment view (core and memory side), the mirror image
interface serv_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [31:0]           ibus_adr;
  logic                  ibus_cyc;
  logic [31:0]           ibus_rdt;
  logic                  ibus_ack;

  logic [31:0]           dbus_adr;
  logic [31:0]           dbus_dat;
  logic [3:0]            dbus_sel;
  logic                  dbus_we;
  logic                  dbus_cyc;
  logic [31:0]           dbus_rdt;
  logic                  dbus_ack;

  logic [ADDR_WIDTH-1:0] mem_adr;
  logic [31:0]           mem_dat;
  logic [3:0]            mem_sel;
  logic                  mem_we;
  logic                  mem_cyc;
  logic [31:0]           mem_rdt;
  logic                  mem_ack;

  modport slave (
    input  ibus_adr, ibus_cyc,
    output ibus_rdt, ibus_ack,
    input  dbus_adr, dbus_dat, dbus_sel, dbus_we, dbus_cyc,
    output dbus_rdt, dbus_ack,
    output mem_adr, mem_dat, mem_sel, mem_we, mem_cyc,
    input  mem_rdt, mem_ack
  );

  modport master (
    output ibus_adr, ibus_cyc,
    input  ibus_rdt, ibus_ack,
    output dbus_adr, dbus_dat, dbus_sel, dbus_we, dbus_cyc,
    input  dbus_rdt, dbus_ack,
    input  mem_adr, mem_dat, mem_sel, mem_we, mem_cyc,
    output mem_rdt, mem_ack
  );

endinterface

// File: rtl/serv_bus_watchdog.sv
// Cycle watchdog for an open memory transfer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : hold the count at zero (no transfer open)
//   cnt_en     : a transfer is open, count one cycle
//   expire     : this is the last allowed cycle of the transfer (TIMEOUT-1)
// TIMEOUT = 0 disables expiry entirely.
module serv_bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cnt_en,
  output logic expire
);

  localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && cnt_en && (cnt == LAST);

endmodule

// File: rtl/serv_mem_arbiter.sv
// Merges SERV ibus and dbus onto one shared memory port.
//   clk, i_rst_n : clock, asynchronous active-low reset
//   bus          : ibus/dbus requests in, responses out; shared memory port
//   i_err_clr    : clears the sticky error capture
//   o_err        : an error-ack has occurred
//   o_err_code   : 01 address out of range, 10 memory timeout (first error kept)
//   o_err_adr    : full 32-bit master address of the first error
// Memory request fields are registered at grant; acks and read data are
// combinational so a memory ack reaches the core in the same cycle.
module serv_mem_arbiter
  import serv_mem_arbiter_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 16,
  parameter int          TIMEOUT       = 255,
  parameter logic [31:0] ERR_DATA      = 32'hDEADBEEF,
  parameter bit          DBUS_PRIORITY = 1'b1
) (
  input  logic                clk,
  input  logic                i_rst_n,
  serv_mem_arbiter_if.slave   bus,
  input  logic                i_err_clr,
  output logic                o_err,
  output logic [1:0]          o_err_code,
  output logic [31:0]         o_err_adr
);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic                  req_any;
  logic                  grant_d;
  logic [31:0]           win_adr;
  logic                  win_fits;
  logic                  busy;
  logic                  expire;
  logic [31:0]           req_adr;
  logic [1:0]            pend_code;
  logic [ADDR_WIDTH-1:0] mem_adr_q;
  logic [31:0]           mem_dat_q;
  logic [3:0]            mem_sel_q;
  logic                  mem_we_q;

  always_comb begin
    req_any  = bus.ibus_cyc || bus.dbus_cyc;
    grant_d  = bus.dbus_cyc && (DBUS_PRIORITY || !bus.ibus_cyc);
    win_adr  = grant_d ? bus.dbus_adr : bus.ibus_adr;
    win_fits = addr_fits(win_adr, ADDR_WIDTH);
  end

  assign busy = (state == S_IBUS) || (state == S_DBUS);

  serv_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (i_rst_n),
    .clr    (!busy),
    .cnt_en (busy),
    .expire (expire)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_any) begin
          if (!win_fits) state_nxt = grant_d ? S_ERR_D : S_ERR_I;
          else           state_nxt = grant_d ? S_DBUS  : S_IBUS;
        end
      end
      S_IBUS, S_DBUS: begin
        if (bus.mem_ack)  state_nxt = S_IDLE;
        else if (expire)  state_nxt = (state == S_IBUS) ? S_ERR_I : S_ERR_D;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant stage: latch the winner's request; range errors never touch memory
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      req_adr   <= '0;
      pend_code <= '0;
      mem_adr_q <= '0;
      mem_dat_q <= '0;
      mem_sel_q <= '0;
      mem_we_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req_any) begin
        req_adr   <= win_adr;
        pend_code <= ERR_CODE_RANGE;
        if (win_fits) begin
          mem_adr_q <= win_adr[ADDR_WIDTH-1:0];
          mem_dat_q <= grant_d ? bus.dbus_dat : 32'd0;
          mem_sel_q <= grant_d ? bus.dbus_sel : 4'hF;
          mem_we_q  <= grant_d && bus.dbus_we;
        end
      end else if (busy && expire && !bus.mem_ack) begin
        pend_code <= ERR_CODE_TIMEOUT;
      end
    end
  end

  // Error capture: first error sticks; a clear in the same cycle lets the new one in
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err      <= 1'b0;
      o_err_code <= '0;
      o_err_adr  <= '0;
    end else if ((state == S_ERR_I || state == S_ERR_D) && (!o_err || i_err_clr)) begin
      o_err      <= 1'b1;
      o_err_code <= pend_code;
      o_err_adr  <= req_adr;
    end else if (i_err_clr) begin
      o_err      <= 1'b0;
      o_err_code <= '0;
      o_err_adr  <= '0;
    end
  end

  assign bus.mem_cyc = busy;
  assign bus.mem_adr = mem_adr_q;
  assign bus.mem_dat = mem_dat_q;
  assign bus.mem_sel = mem_sel_q;
  assign bus.mem_we  = mem_we_q;

  // Response demux: only the granted master ever sees an ack
  always_comb begin
    bus.ibus_ack = 1'b0;
    bus.ibus_rdt = 32'd0;
    bus.dbus_ack = 1'b0;
    bus.dbus_rdt = 32'd0;
    case (state)
      S_IBUS: begin
        bus.ibus_ack = bus.mem_ack;
        bus.ibus_rdt = bus.mem_ack ? bus.mem_rdt : 32'd0;
      end
      S_DBUS: begin
        bus.dbus_ack = bus.mem_ack;
        bus.dbus_rdt = bus.mem_ack ? bus.mem_rdt : 32'd0;
      end
      S_ERR_I: begin
        bus.ibus_ack = 1'b1;
        bus.ibus_rdt = ERR_DATA;
      end
      S_ERR_D: begin
        bus.dbus_ack = 1'b1;
        bus.dbus_rdt = ERR_DATA;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serv_mem_arbiter.sv
module tb_serv_mem_arbiter;

  localparam int          AW   = 16;
  localparam int          TO   = 8;
  localparam logic [31:0] EDAT = 32'hDEADBEEF;

  logic        clk;
  logic        rst_n;
  logic        err_clr;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] err_adr;

  int checks   = 0;
  int failures = 0;
  int iack_cnt = 0;
  int dack_cnt = 0;

  serv_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  serv_mem_arbiter #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT       (TO),
    .ERR_DATA      (EDAT),
    .DBUS_PRIORITY (1'b1)
  ) dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .i_err_clr  (err_clr),
    .o_err      (err),
    .o_err_code (err_code),
    .o_err_adr  (err_adr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction view) ----------------
  int          m_phase = 0;  // 0 none, 1 memory transfer open, 2 error reply due
  int          m_who   = 0;  // 1 ibus, 2 dbus
  int          m_open  = 0;  // cycles the memory transfer has been open
  logic [31:0] m_adr   = '0;
  logic [31:0] m_dat   = '0;
  logic [3:0]  m_sel   = '0;
  logic        m_we    = 1'b0;
  logic [1:0]  m_why   = '0;
  logic        m_err   = 1'b0;
  logic [1:0]  m_code  = '0;
  logic [31:0] m_eadr  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_who = 0; m_open = 0;
      m_err = 1'b0; m_code = '0; m_eadr = '0;
    end else begin
      if (m_phase == 2 && (!m_err || err_clr)) begin
        m_err = 1'b1; m_code = m_why; m_eadr = m_adr;
      end else if (err_clr) begin
        m_err = 1'b0; m_code = '0; m_eadr = '0;
      end
      case (m_phase)
        0: if (bus.ibus_cyc || bus.dbus_cyc) begin
          m_who = (bus.dbus_cyc) ? 2 : 1;
          m_adr = (m_who == 2) ? bus.dbus_adr : bus.ibus_adr;
          m_dat = bus.dbus_dat;
          m_sel = (m_who == 2) ? bus.dbus_sel : 4'hF;
          m_we  = (m_who == 2) && bus.dbus_we;
          if ((m_adr >> AW) != 0) begin
            m_phase = 2; m_why = 2'b01;
          end else begin
            m_phase = 1; m_open = 0;
          end
        end
        1: begin
          m_open++;
          if (bus.mem_ack) m_phase = 0;
          else if (m_open >= TO) begin m_phase = 2; m_why = 2'b10; end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic exp_cyc, exp_i, exp_d;
    exp_cyc = (m_phase == 1);
    exp_i = (m_who == 1) && ((m_phase == 1 && bus.mem_ack) || m_phase == 2);
    exp_d = (m_who == 2) && ((m_phase == 1 && bus.mem_ack) || m_phase == 2);
    chk("cyc_mem", {31'd0, bus.mem_cyc}, {31'd0, exp_cyc});
    if (exp_cyc) begin
      chk("cyc_adr", {16'd0, bus.mem_adr}, {16'd0, m_adr[AW-1:0]});
      chk("cyc_sel", {28'd0, bus.mem_sel}, {28'd0, m_sel});
      chk("cyc_we",  {31'd0, bus.mem_we},  {31'd0, m_we});
      if (m_who == 2) chk("cyc_dat", bus.mem_dat, m_dat);
    end
    chk("cyc_iack", {31'd0, bus.ibus_ack}, {31'd0, exp_i});
    chk("cyc_dack", {31'd0, bus.dbus_ack}, {31'd0, exp_d});
    if (exp_i) chk("cyc_irdt", bus.ibus_rdt, (m_phase == 2) ? EDAT : bus.mem_rdt);
    if (exp_d) chk("cyc_drdt", bus.dbus_rdt, (m_phase == 2) ? EDAT : bus.mem_rdt);
    chk("cyc_err",  {31'd0, err},      {31'd0, m_err});
    chk("cyc_code", {30'd0, err_code}, {30'd0, m_code});
    chk("cyc_eadr", err_adr, m_eadr);
    if (bus.ibus_ack) iack_cnt++;
    if (bus.dbus_ack) dack_cnt++;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit d, input int max, output int n);
    logic a;
    n = 0;
    a = 1'b0;
    while (!a && n < max) begin
      tick();
      #1;
      n++;
      a = d ? bus.dbus_ack : bus.ibus_ack;
    end
    if (!a) begin
      checks++;
      failures++;
      $display("FAIL ack_wait actual=none required=ack within %0d cycles", max);
    end
  endtask

  initial begin
    int n, i0, d0;
    rst_n = 1'b0; err_clr = 1'b0;
    bus.ibus_adr = '0; bus.ibus_cyc = 1'b0;
    bus.dbus_adr = '0; bus.dbus_dat = '0; bus.dbus_sel = '0;
    bus.dbus_we = 1'b0; bus.dbus_cyc = 1'b0;
    bus.mem_rdt = '0; bus.mem_ack = 1'b0;
    tick(); tick();
    #1;
    chk("rst_cyc",  {31'd0, bus.mem_cyc}, 32'd0);
    chk("rst_adr",  {16'd0, bus.mem_adr}, 32'd0);
    chk("rst_iack", {31'd0, bus.ibus_ack}, 32'd0);
    chk("rst_err",  {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: plain fetch, memory ack after two wait cycles
    bus.ibus_adr = 32'h0000_0100; bus.ibus_cyc = 1'b1;
    tick(); #1;
    chk("t1_cyc", {31'd0, bus.mem_cyc}, 32'd1);
    chk("t1_adr", {16'd0, bus.mem_adr}, 32'h0100);
    chk("t1_sel", {28'd0, bus.mem_sel}, 32'hF);
    chk("t1_we",  {31'd0, bus.mem_we}, 32'd0);
    tick(); #1;
    chk("t1_wait", {31'd0, bus.ibus_ack}, 32'd0);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdt = 32'h1234_5678;
    #1;
    chk("t1_iack", {31'd0, bus.ibus_ack}, 32'd1);
    chk("t1_irdt", bus.ibus_rdt, 32'h1234_5678);
    chk("t1_dack", {31'd0, bus.dbus_ack}, 32'd0);
    tick();
    bus.ibus_cyc = 1'b0; bus.mem_ack = 1'b0;
    #1;
    chk("t1_idle", {31'd0, bus.mem_cyc}, 32'd0);

    // 2: simultaneous requests, dbus first then ibus
    i0 = iack_cnt; d0 = dack_cnt;
    bus.ibus_adr = 32'h0000_0200; bus.ibus_cyc = 1'b1;
    bus.dbus_adr = 32'h0000_0300; bus.dbus_sel = 4'h3; bus.dbus_we = 1'b0;
    bus.dbus_dat = 32'h0; bus.dbus_cyc = 1'b1;
    tick(); #1;
    chk("t2_dadr", {16'd0, bus.mem_adr}, 32'h0300);
    chk("t2_dsel", {28'd0, bus.mem_sel}, 32'h3);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdt = 32'hA5A5_0001;
    #1;
    chk("t2_dack", {31'd0, bus.dbus_ack}, 32'd1);
    chk("t2_drdt", bus.dbus_rdt, 32'hA5A5_0001);
    chk("t2_iack0", {31'd0, bus.ibus_ack}, 32'd0);
    tick();
    bus.dbus_cyc = 1'b0; bus.mem_ack = 1'b0;
    tick(); #1;
    chk("t2_iadr", {16'd0, bus.mem_adr}, 32'h0200);
    chk("t2_isel", {28'd0, bus.mem_sel}, 32'hF);
    bus.mem_ack = 1'b1; bus.mem_rdt = 32'hA5A5_0002;
    #1;
    chk("t2_iack", {31'd0, bus.ibus_ack}, 32'd1);
    tick();
    bus.ibus_cyc = 1'b0; bus.mem_ack = 1'b0;
    tick(); tick();
    chk("t2_nack_i", iack_cnt - i0, 32'd1);
    chk("t2_nack_d", dack_cnt - d0, 32'd1);

    // 3: dbus write out of range
    bus.dbus_adr = 32'h0001_0000; bus.dbus_dat = 32'hCAFE_F00D;
    bus.dbus_sel = 4'hF; bus.dbus_we = 1'b1; bus.dbus_cyc = 1'b1;
    wait_ack(1'b1, 4, n);
    chk("t3_lat",  n, 32'd1);
    chk("t3_cyc",  {31'd0, bus.mem_cyc}, 32'd0);
    chk("t3_drdt", bus.dbus_rdt, EDAT);
    tick();
    bus.dbus_cyc = 1'b0; bus.dbus_we = 1'b0;
    #1;
    chk("t3_err",  {31'd0, err}, 32'd1);
    chk("t3_code", {30'd0, err_code}, 32'd1);
    chk("t3_eadr", err_adr, 32'h0001_0000);

    // 5: second error keeps the first capture, then clear
    bus.ibus_adr = 32'h8000_0004; bus.ibus_cyc = 1'b1;
    wait_ack(1'b0, 4, n);
    chk("t5_irdt", bus.ibus_rdt, EDAT);
    tick();
    bus.ibus_cyc = 1'b0;
    #1;
    chk("t5_code", {30'd0, err_code}, 32'd1);
    chk("t5_eadr", err_adr, 32'h0001_0000);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    chk("t5_clr_err",  {31'd0, err}, 32'd0);
    chk("t5_clr_code", {30'd0, err_code}, 32'd0);
    chk("t5_clr_eadr", err_adr, 32'd0);

    // 4: timeout on a fetch, then a late memory ack
    tick();
    bus.ibus_adr = 32'h0000_0040; bus.ibus_cyc = 1'b1;
    wait_ack(1'b0, 20, n);
    chk("t4_lat",  n, 32'd9);
    chk("t4_irdt", bus.ibus_rdt, EDAT);
    tick();
    bus.ibus_cyc = 1'b0;
    #1;
    chk("t4_code", {30'd0, err_code}, 32'd2);
    chk("t4_eadr", err_adr, 32'h0000_0040);
    bus.mem_ack = 1'b1; bus.mem_rdt = 32'h1111_1111;
    #1;
    chk("t4_late_i", {31'd0, bus.ibus_ack}, 32'd0);
    chk("t4_late_d", {31'd0, bus.dbus_ack}, 32'd0);
    tick();
    bus.mem_ack = 1'b0;

    // clear and new error in the same cycle: the new error is captured
    bus.dbus_adr = 32'hFFFF_0000; bus.dbus_we = 1'b0; bus.dbus_cyc = 1'b1;
    tick();
    err_clr = 1'b1;
    #1;
    chk("tc_dack", {31'd0, bus.dbus_ack}, 32'd1);
    tick();
    err_clr = 1'b0; bus.dbus_cyc = 1'b0;
    #1;
    chk("tc_err",  {31'd0, err}, 32'd1);
    chk("tc_code", {30'd0, err_code}, 32'd1);
    chk("tc_eadr", err_adr, 32'hFFFF_0000);

    // 6: reset in the middle of a memory cycle
    tick();
    bus.ibus_adr = 32'h0000_0080; bus.ibus_cyc = 1'b1;
    tick(); #1;
    chk("t6_cyc1", {31'd0, bus.mem_cyc}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_cyc0", {31'd0, bus.mem_cyc}, 32'd0);
    chk("t6_adr",  {16'd0, bus.mem_adr}, 32'd0);
    chk("t6_sel",  {28'd0, bus.mem_sel}, 32'd0);
    chk("t6_iack", {31'd0, bus.ibus_ack}, 32'd0);
    chk("t6_err",  {31'd0, err}, 32'd0);
    chk("t6_eadr", err_adr, 32'd0);
    bus.ibus_cyc = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    bus.ibus_adr = 32'h0000_0084; bus.ibus_cyc = 1'b1;
    tick(); #1;
    chk("t6_radr", {16'd0, bus.mem_adr}, 32'h0084);
    bus.mem_ack = 1'b1; bus.mem_rdt = 32'h0BAD_C0DE;
    #1;
    chk("t6_iack1", {31'd0, bus.ibus_ack}, 32'd1);
    chk("t6_irdt",  bus.ibus_rdt, 32'h0BAD_C0DE);
    tick();
    bus.ibus_cyc = 1'b0; bus.mem_ack = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
